// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of the 5-stage pipelined core. Holds the word-addressed
// data memory, resolves whether a BEQ is taken, exposes the EX/MEM values to
// the forwarding unit and registers the results into the MEM/WB register.
//
// Parameters:
//   DEPTH   number of 32-bit words in the data memory
//   ADDR_W  word-index width (log2 DEPTH)
//
// Ports:
//   clock               rising-edge clock
//   reset               asynchronous, active-low reset
//   mem_to_reg_in       WB select from EX/MEM
//   reg_write_in        register-file write enable from EX/MEM
//   mem_read_in         data-memory read enable
//   mem_write_in        data-memory write enable
//   beq_instruction_in  current instruction is BEQ
//   alu_result_in       ALU result / byte address
//   mux2_result_in      store data
//   flag_beq_in         ALU equality flag
//   reg_rd_in           destination register
//   mem_to_reg_out      MEM/WB copy of mem_to_reg_in
//   reg_write_out       MEM/WB copy of reg_write_in
//   pcSrc               branch taken (combinational)
//   read_data_out       MEM/WB load data
//   alu_result_out      MEM/WB copy of alu_result_in
//   reg_rd_out          MEM/WB copy of reg_rd_in
//   ex_mem_reg_rd       forwarding copy of reg_rd_in (combinational)
//   ex_mem_reg_write    forwarding copy of reg_write_in (combinational)
//   alu_ex_mem          forwarding copy of alu_result_in (combinational)
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_to_reg_in,
    input  logic        reg_write_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        beq_instruction_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] mux2_result_in,
    input  logic        flag_beq_in,
    input  logic [4:0]  reg_rd_in,
    output logic        mem_to_reg_out,
    output logic        reg_write_out,
    output logic        pcSrc,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  reg_rd_out,
    output logic [4:0]  ex_mem_reg_rd,
    output logic        ex_mem_reg_write,
    output logic [31:0] alu_ex_mem
);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] word_index;
    logic [31:0]       read_word;

    // Byte address to word index: the two low bits are dropped (word-aligned
    // access only) and anything above the index is ignored, so addresses
    // wrap modulo DEPTH*4 bytes.
    assign word_index = alu_result_in[ADDR_W+1:2];

    // Asynchronous array read; it is sampled into read_data_out on the same
    // edge that may also write, which gives read-before-write behaviour.
    assign read_word = mem[word_index];

    // Branch resolution and forwarding taps are pure wiring, independent of
    // reset, so the hazard logic sees EX/MEM values with zero latency.
    assign pcSrc            = beq_instruction_in & flag_beq_in;
    assign ex_mem_reg_rd    = reg_rd_in;
    assign ex_mem_reg_write = reg_write_in;
    assign alu_ex_mem       = alu_result_in;

    // Data memory. Reset clears every word; a write presented on an edge
    // while reset is asserted is therefore lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_write_in) begin
            mem[word_index] <= mux2_result_in;
        end
    end

    // MEM/WB pipeline register. There is no stall or flush, so everything
    // loads every cycle; load data is forced to zero when no read occurs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_to_reg_out <= 1'b0;
            reg_write_out  <= 1'b0;
            read_data_out  <= '0;
            alu_result_out <= '0;
            reg_rd_out     <= '0;
        end else begin
            mem_to_reg_out <= mem_to_reg_in;
            reg_write_out  <= reg_write_in;
            read_data_out  <= mem_read_in ? read_word : 32'd0;
            alu_result_out <= alu_result_in;
            reg_rd_out     <= reg_rd_in;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
//
// Self-checking bench for mem_stage. A table of per-cycle vectors carries the
// stage inputs together with hand-computed expectations for the branch
// output and the load data; registered copies and forwarding taps are
// expected to equal the vector's own inputs. Hand-written sequences cover
// power-on reset and an asynchronous reset in the middle of operation.
// ---------------------------------------------------------------------------
module tb_mem_stage;

    logic        clock;
    logic        reset;
    logic        mem_to_reg_in;
    logic        reg_write_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        beq_instruction_in;
    logic [31:0] alu_result_in;
    logic [31:0] mux2_result_in;
    logic        flag_beq_in;
    logic [4:0]  reg_rd_in;
    logic        mem_to_reg_out;
    logic        reg_write_out;
    logic        pcSrc;
    logic [31:0] read_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  reg_rd_out;
    logic [4:0]  ex_mem_reg_rd;
    logic        ex_mem_reg_write;
    logic [31:0] alu_ex_mem;

    int total;
    int bad;

    typedef struct {
        string       name;
        logic        mem_to_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        beq;
        logic        flag;
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        exp_pc;
        logic [31:0] exp_read;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vectors [NVEC];

    mem_stage #(.DEPTH(256), .ADDR_W(8)) dut (
        .clock              (clock),
        .reset              (reset),
        .mem_to_reg_in      (mem_to_reg_in),
        .reg_write_in       (reg_write_in),
        .mem_read_in        (mem_read_in),
        .mem_write_in       (mem_write_in),
        .beq_instruction_in (beq_instruction_in),
        .alu_result_in      (alu_result_in),
        .mux2_result_in     (mux2_result_in),
        .flag_beq_in        (flag_beq_in),
        .reg_rd_in          (reg_rd_in),
        .mem_to_reg_out     (mem_to_reg_out),
        .reg_write_out      (reg_write_out),
        .pcSrc              (pcSrc),
        .read_data_out      (read_data_out),
        .alu_result_out     (alu_result_out),
        .reg_rd_out         (reg_rd_out),
        .ex_mem_reg_rd      (ex_mem_reg_rd),
        .ex_mem_reg_write   (ex_mem_reg_write),
        .alu_ex_mem         (alu_ex_mem)
    );

    // 10 ns clock period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts, and reports any disagreement.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drives one vector's inputs onto the stage.
    task automatic applyStimulus(input vec_t v);
        mem_to_reg_in      = v.mem_to_reg;
        reg_write_in       = v.reg_write;
        mem_read_in        = v.mem_read;
        mem_write_in       = v.mem_write;
        beq_instruction_in = v.beq;
        flag_beq_in        = v.flag;
        alu_result_in      = v.alu;
        mux2_result_in     = v.store;
        reg_rd_in          = v.rd;
    endtask

    // Drives a plain memory access with everything else idle.
    task automatic memAccess(input logic rd_en, input logic wr_en,
                             input logic [31:0] addr, input logic [31:0] data);
        vec_t v;
        v = '{"mem", 1'b0, 1'b0, rd_en, wr_en, 1'b0, 1'b0, addr, data, 5'd0, 1'b0, 32'd0};
        applyStimulus(v);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //                name        m2r  rw   rd   wr   beq  flg  alu           store         rd     pc   read
        vectors[0]  = '{"store8",    1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,32'd8,        32'd12345,    5'd3,  1'b1,32'd0};
        vectors[1]  = '{"load8",     1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,32'd8,        32'd0,        5'd4,  1'b0,32'd12345};
        vectors[2]  = '{"nogate",    1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,32'd8,        32'd0,        5'd0,  1'b0,32'd0};
        vectors[3]  = '{"rbw",       1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,32'd8,        32'd77,       5'd1,  1'b0,32'd12345};
        vectors[4]  = '{"after_rbw", 1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,32'd8,        32'd0,        5'd2,  1'b0,32'd77};
        vectors[5]  = '{"wrap_wr",   1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,32'd1032,     32'd5,        5'd0,  1'b0,32'd0};
        vectors[6]  = '{"wrap_rd8",  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'd8,        32'd0,        5'd0,  1'b0,32'd5};
        vectors[7]  = '{"align_rd9", 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'd9,        32'd0,        5'd0,  1'b0,32'd5};
        vectors[8]  = '{"fwd",       1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,32'd56789,    32'd0,        5'd10, 1'b0,32'd0};
        vectors[9]  = '{"rd_zero",   1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,32'd0,        32'd0,        5'd31, 1'b0,32'd0};
        vectors[10] = '{"top_rbw",   1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,32'hFFFFFFFC, 32'hDEADBEEF, 5'd7,  1'b1,32'd0};
        vectors[11] = '{"top_rd",    1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,32'd1020,     32'd0,        5'd8,  1'b0,32'hDEADBEEF};
        vectors[12] = '{"low_rd",    1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,32'd3,        32'd0,        5'd9,  1'b0,32'd0};

        // Power-on reset with busy inputs, including a write that must be lost.
        reset = 1'b0;
        applyStimulus('{"rst", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                        32'd0, 32'hCAFEF00D, 5'd21, 1'b1, 32'd0});
        #10;
        @(negedge clock);
        checkOutput("rst mem_to_reg_out", 32'(mem_to_reg_out), 32'd0);
        checkOutput("rst reg_write_out",  32'(reg_write_out),  32'd0);
        checkOutput("rst read_data_out",  read_data_out,        32'd0);
        checkOutput("rst alu_result_out", alu_result_out,       32'd0);
        checkOutput("rst reg_rd_out",     32'(reg_rd_out),      32'd0);
        checkOutput("rst pcSrc",          32'(pcSrc),           32'd1);
        checkOutput("rst fwd rd",         32'(ex_mem_reg_rd),   32'd21);
        checkOutput("rst fwd write",      32'(ex_mem_reg_write),32'd1);
        checkOutput("rst fwd alu",        alu_ex_mem,           32'd0);
        reset = 1'b1;

        // Table-driven cycles: combinational checks before the edge,
        // registered checks just after it.
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vectors[i]);
            #1;
            checkOutput({vectors[i].name, " pcSrc"},     32'(pcSrc),            32'(vectors[i].exp_pc));
            checkOutput({vectors[i].name, " fwd rd"},    32'(ex_mem_reg_rd),    32'(vectors[i].rd));
            checkOutput({vectors[i].name, " fwd write"}, 32'(ex_mem_reg_write), 32'(vectors[i].reg_write));
            checkOutput({vectors[i].name, " fwd alu"},   alu_ex_mem,            vectors[i].alu);
            @(posedge clock);
            #1;
            checkOutput({vectors[i].name, " read_data"}, read_data_out,         vectors[i].exp_read);
            checkOutput({vectors[i].name, " alu_out"},   alu_result_out,        vectors[i].alu);
            checkOutput({vectors[i].name, " rd_out"},    32'(reg_rd_out),       32'(vectors[i].rd));
            checkOutput({vectors[i].name, " rw_out"},    32'(reg_write_out),    32'(vectors[i].reg_write));
            checkOutput({vectors[i].name, " m2r_out"},   32'(mem_to_reg_out),   32'(vectors[i].mem_to_reg));
            @(negedge clock);
        end

        // Mid-operation reset: store 0x1111 at 16, then assert reset between
        // edges while a store of 0x2222 to 20 is pending.
        memAccess(1'b1, 1'b1, 32'd16, 32'h1111);
        mem_to_reg_in = 1'b1;
        reg_write_in  = 1'b1;
        reg_rd_in     = 5'd12;
        @(posedge clock);
        #1;
        checkOutput("mid pre rw_out", 32'(reg_write_out), 32'd1);
        @(negedge clock);
        memAccess(1'b1, 1'b1, 32'd20, 32'h2222);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid async alu_out",  alu_result_out,      32'd0);
        checkOutput("mid async rw_out",   32'(reg_write_out),  32'd0);
        checkOutput("mid async m2r_out",  32'(mem_to_reg_out), 32'd0);
        checkOutput("mid async rd_out",   32'(reg_rd_out),     32'd0);
        @(posedge clock);
        #1;
        checkOutput("mid held read_data", read_data_out,       32'd0);
        @(negedge clock);
        reset = 1'b1;
        memAccess(1'b1, 1'b0, 32'd16, 32'd0);
        @(posedge clock);
        #1;
        checkOutput("mid cleared word16", read_data_out, 32'd0);
        @(negedge clock);
        memAccess(1'b1, 1'b0, 32'd20, 32'd0);
        @(posedge clock);
        #1;
        checkOutput("mid dropped word20", read_data_out, 32'd0);
        @(negedge clock);

        // Memory still usable after the mid-operation reset.
        memAccess(1'b0, 1'b1, 32'd20, 32'h3333);
        @(posedge clock);
        @(negedge clock);
        memAccess(1'b1, 1'b0, 32'd20, 32'd0);
        @(posedge clock);
        #1;
        checkOutput("post reset store", read_data_out, 32'h3333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access (MEM) stage of the 5-stage pipelined core.
- Contains the word-addressed data memory and resolves branch taken (pcSrc).
- Exposes the EX/MEM forwarding signals to the forwarding unit.
- Registers results into the MEM/WB pipeline register that feeds write-back.

Parameters:
DEPTH, 256, number of 32-bit words in data memory
ADDR_W, 8, word-index width (log2 DEPTH)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
mem_to_reg_in  input  1  WB select from EX/MEM
reg_write_in  input  1  register-file write enable from EX/MEM
mem_read_in  input  1  data-memory read enable
mem_write_in  input  1  data-memory write enable
beq_instruction_in  input  1  current instruction is BEQ
alu_result_in  input  32  ALU result / byte address
mux2_result_in  input  32  store data (rs2 after forwarding mux)
flag_beq_in  input  1  ALU equality flag
reg_rd_in  input  5  destination register
mem_to_reg_out  output  1  registered mem_to_reg_in (MEM/WB)
reg_write_out  output  1  registered reg_write_in (MEM/WB)
pcSrc  output  1  branch taken, combinational
read_data_out  output  32  registered load data (MEM/WB)
alu_result_out  output  32  registered alu_result_in (MEM/WB)
reg_rd_out  output  5  registered reg_rd_in (MEM/WB)
ex_mem_reg_rd  output  5  forwarding: reg_rd_in, combinational
ex_mem_reg_write  output  1  forwarding: reg_write_in, combinational
alu_ex_mem  output  32  forwarding: alu_result_in, combinational

Behaviour:
- Interface: single clock domain (clock). reset is asynchronous and active-low.
- Reset (reset=0), taking effect immediately:
  - mem_to_reg_out, reg_write_out, read_data_out, alu_result_out and reg_rd_out clear to 0.
  - All DEPTH memory words clear to 0.
- Reset mid-operation: any write on that edge is discarded.
- Address: word index = alu_result_in[ADDR_W+1:2].
  - Bits [1:0] ignored (word-aligned access only).
  - Bits above ADDR_W+1 ignored, so addresses wrap modulo DEPTH*4 bytes.
- Write: on rising edge with reset=1 and mem_write_in=1, mem[index] <= mux2_result_in. Full word only, no byte enables.
- Read: combinational array read of mem[index].
  - On each rising edge, read_data_out <= mem[index] if mem_read_in=1, else 0.
  - Load latency: 1 cycle to read_data_out.
- Read and write same address on same edge: read_data_out gets the old contents (read-before-write). The new value is visible from the next cycle.
- Both mem_read_in and mem_write_in set: both actions occur per the rules above.
- pcSrc = beq_instruction_in AND flag_beq_in. Purely combinational, not gated by reset.
- Forwarding outputs: direct combinational copies of reg_rd_in, reg_write_in and alu_result_in, with zero latency.
- MEM/WB register: on each rising edge, mem_to_reg_out, reg_write_out, alu_result_out and reg_rd_out load their *_in counterparts unconditionally. No stall or flush input.

Test Plan:
- Reset: hold reset=0 for 10 ns with inputs nonzero -> all registered outputs 0. pcSrc follows inputs. Forwarding outputs equal inputs.
- Store then load:
  - reset=1, mem_write_in=1, alu_result_in=8, mux2_result_in=12345 for one edge.
  - Then mem_write_in=0, mem_read_in=1, alu_result_in=8 -> after next edge read_data_out=12345 and alu_result_out=8.
- Branch: beq_instruction_in=1, flag_beq_in=1 -> pcSrc=1 immediately. With flag_beq_in=0 or beq_instruction_in=0 -> pcSrc=0.
- Forwarding: reg_write_in=1, reg_rd_in=10, alu_result_in=56789:
  - Same cycle: ex_mem_reg_write=1, ex_mem_reg_rd=10, alu_ex_mem=56789.
  - After edge: reg_write_out=1, reg_rd_out=10, alu_result_out=56789.
- Read gating and read-before-write:
  - mem_read_in=0 -> read_data_out=0 after edge.
  - Simultaneous write 77 and read at address 8 holding 12345 -> read_data_out=12345, next read returns 77.
- Address wrap/alignment: write 5 at address 1032 -> read at address 8 and at address 9 both return 5.
